// File: rtl/flex_counter_pkg.sv
// flex_counter_pkg: shared widths and types for the fan-speed tick counter.
// Optional feature macro: FLEX_COUNTER_SAT_EN (saturating boundaries).
package flex_counter_pkg;

  localparam int DEFAULT_NUM_BITS   = 7;
  localparam int DEFAULT_SPEED_BITS = 2;

  typedef logic [DEFAULT_NUM_BITS-1:0]   count_t;
  typedef logic [DEFAULT_SPEED_BITS-1:0] speed_t;

endpackage

// File: rtl/flex_counter_if.sv
// flex_counter_if: control/status bundle between the counter core and its user.
// Optional feature macro: FLEX_COUNTER_SAT_EN (does not change this bundle).
interface flex_counter_if #(
  parameter int NUM_BITS   = flex_counter_pkg::DEFAULT_NUM_BITS,
  parameter int SPEED_BITS = flex_counter_pkg::DEFAULT_SPEED_BITS
);

  logic [NUM_BITS-1:0]   rollover_val;
  logic                  sign;
  logic [SPEED_BITS-1:0] fan_speed;
  logic [NUM_BITS-1:0]   seed;
  logic [NUM_BITS-1:0]   count;
  logic                  rollover_flag;

  modport cnt (
    input  rollover_val, sign, fan_speed, seed,
    output count, rollover_flag
  );

  modport tb (
    output rollover_val, sign, fan_speed, seed,
    input  count, rollover_flag
  );

endinterface

// File: rtl/flex_counter_next.sv
// flex_counter_next: combinational next-count / rollover-flag computation.
// Optional feature macro: FLEX_COUNTER_SAT_EN -- when defined, crossings pin
// the count at the boundary instead of reloading from the opposite end.
module flex_counter_next #(
  parameter int NUM_BITS   = flex_counter_pkg::DEFAULT_NUM_BITS,
  parameter int SPEED_BITS = flex_counter_pkg::DEFAULT_SPEED_BITS
) (
  input  logic [NUM_BITS-1:0]   count,
  input  logic [SPEED_BITS-1:0] step,
  input  logic                  sign,
  input  logic [NUM_BITS-1:0]   rollover_val,
  output logic [NUM_BITS-1:0]   next_count,
  output logic                  next_flag
);

  import flex_counter_pkg::*;

  // One extra bit so count+step never overflows, even at the top of the range.
  localparam int W = NUM_BITS + 1;

  logic [W-1:0]        count_w;
  logic [W-1:0]        step_w;
  logic [W-1:0]        bound_w;
  logic [W-1:0]        sum_w;
  logic [NUM_BITS-1:0] diff;

  assign count_w = {1'b0, count};
  assign step_w  = W'(step);
  assign bound_w = {1'b0, rollover_val};
  assign sum_w   = count_w + step_w;
  // Only used when count >= step, so the subtraction cannot borrow.
  assign diff    = count - NUM_BITS'(step);

  // Range guard first, then hold / up / down stepping with boundary handling.
  always_comb begin
    // NOTE: default every output first so no path leaves one unassigned (no latch).
    next_count = count;
    next_flag  = 1'b0;
    if (count_w > bound_w) begin
      // Bound was lowered below the current count: restart silently from zero.
      next_count = '0;
    end else if (step_w == '0) begin
      next_count = count;
    end else if (sign) begin
      if (sum_w > bound_w) begin
`ifdef FLEX_COUNTER_SAT_EN
        next_count = rollover_val;
`else
        next_count = '0;
`endif
        next_flag  = 1'b1;
      end else begin
        next_count = sum_w[NUM_BITS-1:0];
      end
    end else begin
      if (count_w < step_w) begin
`ifdef FLEX_COUNTER_SAT_EN
        next_count = '0;
`else
        next_count = rollover_val;
`endif
        next_flag  = 1'b1;
      end else begin
        next_count = diff;
      end
    end
  end

endmodule

// File: rtl/flex_counter_core.sv
// flex_counter_core: programmable up/down fan-speed tick counter.
// Holds the count, rollover flag and seeded flag; stepping is delegated to
// flex_counter_next. Optional feature macro: FLEX_COUNTER_SAT_EN (saturating).
module flex_counter_core #(
  parameter int NUM_BITS   = flex_counter_pkg::DEFAULT_NUM_BITS,
  parameter int SPEED_BITS = flex_counter_pkg::DEFAULT_SPEED_BITS
) (
  input logic       CLK,
  input logic       nRST,
  flex_counter_if.cnt fcif
);

  import flex_counter_pkg::*;

  logic [NUM_BITS-1:0] count_q;
  logic                flag_q;
  logic                seeded_q;
  logic [NUM_BITS-1:0] next_count;
  logic                next_flag;
  logic [NUM_BITS-1:0] seed_clamped;

  // A seed above the bound starts the counter at the bound itself.
  assign seed_clamped = (fcif.seed > fcif.rollover_val) ? fcif.rollover_val : fcif.seed;

  flex_counter_next #(
    .NUM_BITS   (NUM_BITS),
    .SPEED_BITS (SPEED_BITS)
  ) u_next (
    .count        (count_q),
    .step         (fcif.fan_speed),
    .sign         (fcif.sign),
    .rollover_val (fcif.rollover_val),
    .next_count   (next_count),
    .next_flag    (next_flag)
  );

  // Synchronous reset, one-time seed load, then registered stepping.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (nRST) begin
      count_q  <= '0;
      flag_q   <= 1'b0;
      seeded_q <= 1'b0;
    end else if (!seeded_q) begin
      count_q  <= seed_clamped;
      flag_q   <= 1'b0;
      seeded_q <= 1'b1;
    end else begin
      count_q  <= next_count;
      flag_q   <= next_flag;
    end
  end

  assign fcif.count         = count_q;
  assign fcif.rollover_flag = flag_q;

endmodule

// File: tb/tb_flex_counter_core.sv
// tb_flex_counter_core: scoreboard bench for flex_counter_core.
// Build with +define+FLEX_COUNTER_SAT_EN to exercise the saturating mode.
module tb_flex_counter_core;

  import flex_counter_pkg::*;

  typedef struct packed {
    count_t count;
    logic   flag;
  } exp_t;

`ifdef FLEX_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic nrst;

  flex_counter_if fcif ();

  flex_counter_core dut (
    .CLK  (clk),
    .nRST (nrst),
    .fcif (fcif)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Behavioural reference state.
  int m_count  = 0;
  bit m_flag   = 1'b0;
  bit m_seeded = 1'b0;

  // Predict the result of the coming edge from the inputs now applied.
  task automatic model_edge();
    int   rv;
    int   st;
    int   sd;
    exp_t e;
    rv = int'(fcif.rollover_val);
    st = int'(fcif.fan_speed);
    sd = int'(fcif.seed);
    if (nrst === 1'b1) begin
      m_count = 0; m_flag = 1'b0; m_seeded = 1'b0;
    end else if (!m_seeded) begin
      m_count = (sd <= rv) ? sd : rv; m_flag = 1'b0; m_seeded = 1'b1;
    end else if (m_count > rv) begin
      m_count = 0; m_flag = 1'b0;
    end else if (st == 0) begin
      m_flag = 1'b0;
    end else if (fcif.sign === 1'b1) begin
      if (m_count + st > rv) begin
        m_count = SAT ? rv : 0; m_flag = 1'b1;
      end else begin
        m_count = m_count + st; m_flag = 1'b0;
      end
    end else begin
      if (m_count < st) begin
        m_count = SAT ? 0 : rv; m_flag = 1'b1;
      end else begin
        m_count = m_count - st; m_flag = 1'b0;
      end
    end
    e.count = count_t'(m_count);
    e.flag  = m_flag;
    sb.push_back(e);
  endtask

  // Push the prediction, advance one edge, settle away from the edge.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int rv, input bit sg, input int fs, input int sd);
    fcif.rollover_val = count_t'(rv);
    fcif.sign         = sg;
    fcif.fan_speed    = speed_t'(fs);
    fcif.seed         = count_t'(sd);
  endtask

  task automatic reset_dut(input int n);
    exp_t e;
    nrst = 1'b1;
    repeat (n) begin
      cycle();
      e = sb.pop_front();
    end
    nrst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    set_in(90, 1'b1, 1, 10);
    nrst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      e = sb.pop_front();
      n_total++;
      if (fcif.count !== e.count || fcif.rollover_flag !== e.flag)
        $display("FAIL reset[%0d]: count=%0d flag=%0b, expected count=%0d flag=%0b",
                 i, fcif.count, fcif.rollover_flag, e.count, e.flag);
      else n_pass++;
    end
    n_total++;
    if (fcif.count !== 7'd0 || fcif.rollover_flag !== 1'b0)
      $display("FAIL reset_value: count=%0d flag=%0b, expected count=0 flag=0",
               fcif.count, fcif.rollover_flag);
    else n_pass++;
  endtask

  task automatic test_seed_up();
    exp_t e;
    nrst = 1'b0;
    for (int i = 0; i < 83; i++) begin
      cycle();
      e = sb.pop_front();
      n_total++;
      if (fcif.count !== e.count || fcif.rollover_flag !== e.flag)
        $display("FAIL seed_up[%0d]: count=%0d flag=%0b, expected count=%0d flag=%0b",
                 i, fcif.count, fcif.rollover_flag, e.count, e.flag);
      else n_pass++;
      if (i == 0) begin
        n_total++;
        if (fcif.count !== 7'd10)
          $display("FAIL seed_load: count=%0d, expected 10", fcif.count);
        else n_pass++;
      end
      if (i == 80) begin
        n_total++;
        if (fcif.count !== 7'd90 || fcif.rollover_flag !== 1'b0)
          $display("FAIL reach_bound: count=%0d flag=%0b, expected count=90 flag=0",
                   fcif.count, fcif.rollover_flag);
        else n_pass++;
      end
      if (i == 81) begin
        n_total++;
        if (fcif.rollover_flag !== 1'b1 || fcif.count !== (SAT ? 7'd90 : 7'd0))
          $display("FAIL up_wrap: count=%0d flag=%0b, expected count=%0d flag=1",
                   fcif.count, fcif.rollover_flag, SAT ? 90 : 0);
        else n_pass++;
      end
    end
  endtask

  task automatic test_down_step();
    exp_t e;
    set_in(30, 1'b0, 2, 4);
    reset_dut(2);
    for (int i = 0; i < 6; i++) begin
      cycle();
      e = sb.pop_front();
      n_total++;
      if (fcif.count !== e.count || fcif.rollover_flag !== e.flag)
        $display("FAIL down_step[%0d]: count=%0d flag=%0b, expected count=%0d flag=%0b",
                 i, fcif.count, fcif.rollover_flag, e.count, e.flag);
      else n_pass++;
    end
  endtask

  task automatic test_bound_lowered();
    exp_t e;
    set_in(90, 1'b1, 3, 80);
    reset_dut(2);
    for (int i = 0; i < 28; i++) begin
      if (i == 1) fcif.rollover_val = 7'd75;
      cycle();
      e = sb.pop_front();
      n_total++;
      if (fcif.count !== e.count || fcif.rollover_flag !== e.flag)
        $display("FAIL bound_lowered[%0d]: count=%0d flag=%0b, expected count=%0d flag=%0b",
                 i, fcif.count, fcif.rollover_flag, e.count, e.flag);
      else n_pass++;
      if (i == 1) begin
        n_total++;
        if (fcif.count !== 7'd0 || fcif.rollover_flag !== 1'b0)
          $display("FAIL range_guard: count=%0d flag=%0b, expected count=0 flag=0",
                   fcif.count, fcif.rollover_flag);
        else n_pass++;
      end
      if (i == 26) begin
        n_total++;
        if (fcif.count !== 7'd75)
          $display("FAIL step3_bound: count=%0d, expected 75", fcif.count);
        else n_pass++;
      end
    end
  endtask

  task automatic test_hold_clamp();
    exp_t e;
    set_in(50, 1'b1, 0, 100);
    reset_dut(2);
    for (int i = 0; i < 7; i++) begin
      fcif.sign = i[0];
      cycle();
      e = sb.pop_front();
      n_total++;
      if (fcif.count !== e.count || fcif.rollover_flag !== e.flag)
        $display("FAIL hold_clamp[%0d]: count=%0d flag=%0b, expected count=%0d flag=%0b",
                 i, fcif.count, fcif.rollover_flag, e.count, e.flag);
      else n_pass++;
    end
    n_total++;
    if (fcif.count !== 7'd50 || fcif.rollover_flag !== 1'b0)
      $display("FAIL seed_clamp: count=%0d flag=%0b, expected count=50 flag=0",
               fcif.count, fcif.rollover_flag);
    else n_pass++;
  endtask

  task automatic test_degenerate();
    exp_t e;
    set_in(0, 1'b1, 1, 5);
    reset_dut(2);
    for (int i = 0; i < 12; i++) begin
      fcif.sign = i[0];
      nrst      = (i == 7);
      if (i == 8) set_in(40, 1'b1, 2, 33);
      cycle();
      e = sb.pop_front();
      n_total++;
      if (fcif.count !== e.count || fcif.rollover_flag !== e.flag)
        $display("FAIL degenerate[%0d]: count=%0d flag=%0b, expected count=%0d flag=%0b",
                 i, fcif.count, fcif.rollover_flag, e.count, e.flag);
      else n_pass++;
      if (i == 3) begin
        n_total++;
        if (fcif.count !== 7'd0 || fcif.rollover_flag !== 1'b1)
          $display("FAIL zero_bound: count=%0d flag=%0b, expected count=0 flag=1",
                   fcif.count, fcif.rollover_flag);
        else n_pass++;
      end
      if (i == 8) begin
        n_total++;
        if (fcif.count !== 7'd33)
          $display("FAIL reseed: count=%0d, expected 33", fcif.count);
        else n_pass++;
      end
    end
    nrst = 1'b0;
  endtask

  task automatic test_top_of_range();
    exp_t e;
    set_in(127, 1'b1, 3, 127);
    reset_dut(2);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) fcif.sign = 1'b0;
      cycle();
      e = sb.pop_front();
      n_total++;
      if (fcif.count !== e.count || fcif.rollover_flag !== e.flag)
        $display("FAIL top_of_range[%0d]: count=%0d flag=%0b, expected count=%0d flag=%0b",
                 i, fcif.count, fcif.rollover_flag, e.count, e.flag);
      else n_pass++;
    end
  endtask

`ifdef FLEX_COUNTER_SAT_EN
  task automatic test_saturate();
    exp_t e;
    set_in(20, 1'b1, 3, 19);
    reset_dut(2);
    for (int i = 0; i < 8; i++) begin
      if (i == 6) fcif.sign = 1'b0;
      cycle();
      e = sb.pop_front();
      n_total++;
      if (fcif.count !== e.count || fcif.rollover_flag !== e.flag)
        $display("FAIL saturate[%0d]: count=%0d flag=%0b, expected count=%0d flag=%0b",
                 i, fcif.count, fcif.rollover_flag, e.count, e.flag);
      else n_pass++;
      if (i == 4) begin
        n_total++;
        if (fcif.count !== 7'd20 || fcif.rollover_flag !== 1'b1)
          $display("FAIL sat_pinned: count=%0d flag=%0b, expected count=20 flag=1",
                   fcif.count, fcif.rollover_flag);
        else n_pass++;
      end
    end
  endtask
`endif

  task automatic test_random();
    exp_t e;
    set_in(60, 1'b1, 1, 7);
    reset_dut(1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) fcif.rollover_val = count_t'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0)  fcif.sign = ~fcif.sign;
      if ($urandom_range(0, 3) == 0)  fcif.fan_speed = speed_t'($urandom_range(0, 3));
      fcif.seed = count_t'($urandom_range(0, 127));
      nrst = ($urandom_range(0, 49) == 0);
      cycle();
      e = sb.pop_front();
      n_total++;
      if (fcif.count !== e.count || fcif.rollover_flag !== e.flag)
        $display("FAIL random[%0d]: count=%0d flag=%0b, expected count=%0d flag=%0b",
                 i, fcif.count, fcif.rollover_flag, e.count, e.flag);
      else n_pass++;
    end
    nrst = 1'b0;
  endtask

  initial begin
    nrst = 1'b1;
    set_in(90, 1'b1, 1, 10);
    test_reset();
    test_seed_up();
    test_down_step();
    test_bound_lowered();
    test_hold_clamp();
    test_degenerate();
    test_top_of_range();
`ifdef FLEX_COUNTER_SAT_EN
    test_saturate();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/flex_counter_core.md
Name: flex_counter_core

Overview:
Programmable up/down counter with variable step, used as the fan-speed tick generator in the compute tile. It counts within 0..rollover_val, in a direction set by `sign`, advancing by `fan_speed` each cycle. It reloads on boundary crossing and pulses a rollover flag. All control and status signals travel in the `flex_counter_if` interface bundle; the core has no other I/O.

Parameters:
NUM_BITS, 7, width of count, rollover_val and seed.
SPEED_BITS, 2, width of fan_speed (step size 0..3).

Ports:
CLK  input  1  system clock, all state updates on rising edge.
nRST  input  1  reset; synchronous, active-high (asserted when 1), sampled on CLK rising edge.
fcif.rollover_val  input  NUM_BITS  upper bound of count range (inclusive).
fcif.sign  input  1  direction: 1 = up, 0 = down.
fcif.fan_speed  input  SPEED_BITS  step per cycle; 0 = hold.
fcif.seed  input  NUM_BITS  start value loaded once after reset.
fcif.count  output  NUM_BITS  current count.
fcif.rollover_flag  output  1  one-cycle pulse on wrap.

Behaviour:
- Reset (nRST=1 at a clock edge): count=0, rollover_flag=0, internal seeded flag=0. Reset has priority over all other activity, including mid-count.
- First edge with nRST=0 and seeded=0:
  - count = seed if seed <= rollover_val, else rollover_val.
  - seeded=1, rollover_flag=0.
  - No step is applied on this cycle.
- Range guard, checked after seeding and before stepping: if count > rollover_val (the bound was lowered at runtime), the next count is 0 and rollover_flag=0.
- Normal stepping (seeded=1, count <= rollover_val), step = fan_speed zero-extended:
  - step=0: count holds, flag=0.
  - Up (sign=1): if count+step > rollover_val, count=0 and flag=1; else count += step, flag=0.
  - Down (sign=0): if count < step, count=rollover_val and flag=1; else count -= step, flag=0.
- Arithmetic uses NUM_BITS+1-bit intermediates, so there is no overflow at count=127.
- rollover_val=0: count stays 0; flag pulses every cycle while step != 0.
- Inputs are sampled every cycle. Changes to sign, fan_speed or rollover_val take effect on the next edge.
- Latency: one cycle from inputs to count. Outputs are registered, with no combinational path from inputs to outputs.
- No handshake.

Optional Feature:
FLEX_COUNTER_SAT_EN
- Defined: saturating mode.
  - Up crossing sets count=rollover_val.
  - Down crossing sets count=0.
  - rollover_flag is held high for every cycle the count stays pinned at its boundary with step != 0.
- Undefined: wrap/reload behaviour exactly as specified above.

Decomposition:
- Package flex_counter_pkg holds:
  - NUM_BITS and SPEED_BITS defaults.
  - typedefs count_t (logic [NUM_BITS-1:0]) and speed_t (logic [SPEED_BITS-1:0]).
- Interface flex_counter_if declares the signals above, with modport `cnt` (core side) and modport `tb`.
- One combinational sub-module, flex_counter_next, computes next count and flag from count, step, sign and rollover_val. The core holds only registers and the seeded flag.

Test Plan:
1. Seed load: nRST=1 for 10 cycles, seed=10, rollover_val=90, sign=1, fan_speed=1; release reset -> count=0 during reset, 10 on first edge, 11, 12, ... reaches 90 after 80 more edges; next edge count=0 with rollover_flag=1 for exactly one cycle.
2. Down step 2: count=4, rollover_val=30, sign=0, fan_speed=2 -> 2, 0, then 30 with flag=1, then 28.
3. Up step 3 with bound lowered: rollover_val 90->75 while count=80, sign=1, fan_speed=3 -> count=0, flag=0; then 3, 6, ..., 75, next 0 with flag=1.
4. Hold and seed clamp: fan_speed=0 -> count constant, flag never asserts; seed=100 with rollover_val=50 -> first count after reset is 50.
5. Degenerate bound: rollover_val=0, any sign, fan_speed=1 -> count=0, flag=1 every cycle. Assert nRST mid-run -> count=0 and flag=0 on the next edge; seed reloads after release.
6. FLEX_COUNTER_SAT_EN defined: rollover_val=20, count=19, sign=1, fan_speed=3 -> count=20, flag=1, stays 20 with flag high until sign=0.
